// File: rtl/sin_arbiter_pkg.sv
// sin_arb_pkg: shared types, FSM states and timer sizing for the sin arbiter.
package sin_arb_pkg;
  typedef logic [31:0] float_t;
  typedef logic [3:0] prec_t;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESPOND} state_t;
  function automatic int timer_w(input int cycles);
    return $clog2(cycles) + 1;
  endfunction
endpackage

// File: rtl/sin_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant with a registered rotating pointer.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_i,
  input  logic            adv_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [2*NREQ-1:0] dbl;
  int off;
  // Rotate so bit 0 is the pointer position; the lowest set bit is the winner.
  always_comb begin
    dbl = {req_i, req_i} >> ptr_q;
    off = 0;
    for (int k = NREQ - 1; k >= 0; k--) if (dbl[k]) off = k;
    off = off + int'(ptr_q);
    idx_o = IDW'(off >= NREQ ? off - NREQ : off);
    gnt_o = (|req_i) ? (NREQ'(1) << idx_o) : '0;
    ptr_d = (idx_o == IDW'(NREQ - 1)) ? '0 : idx_o + IDW'(1);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr_q <= '0;
    else if (adv_i) ptr_q <= ptr_d;
endmodule

// File: rtl/sin_arbiter.sv
// sin_arbiter: shares one multi-cycle sin unit among NREQ requesters round-robin,
// sequencing start/run/done with a watchdog that aborts overlong operations.
module sin_arbiter
  import sin_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*32-1:0] req_theta,
  input  logic [NREQ*4-1:0] req_prec,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic              sin_reset,
  output logic [31:0]       sin_theta,
  output logic [3:0]        sin_prec,
  input  logic [31:0]       sin_result,
  input  logic              sin_done
);
  localparam int TW = timer_w(TIMEOUT_CYCLES);
  state_t state_q;
  float_t theta_q, res_q;
  prec_t prec_q;
  logic err_q, sin_reset_q, accept, done_ok, timed_out;
  logic [NREQ-1:0] resp_valid_q, gnt;
  logic [IDW-1:0] gidx, gidx_q;
  logic [TW-1:0] timer_q, timer_d;
  assign accept = (state_q == IDLE) && (|req_valid);
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .clk(clk), .reset(reset), .req_i(req_valid), .adv_i(accept), .gnt_o(gnt), .idx_o(gidx)
  );
  // A done in the first WAIT cycle may be left over from the previous operation.
  assign done_ok = (timer_q != '0) && sin_done;
  assign timed_out = timer_q == TW'(TIMEOUT_CYCLES - 1);
  assign timer_d = (&timer_q) ? timer_q : timer_q + TW'(1);
  assign req_ready = (state_q == IDLE && reset) ? gnt : '0;
  assign resp_valid = resp_valid_q;
  assign resp_data = res_q;
  assign resp_err = err_q;
  assign busy = state_q != IDLE;
  assign sin_reset = sin_reset_q;
  assign sin_theta = theta_q;
  assign sin_prec = prec_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      theta_q <= '0;
      prec_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      gidx_q <= '0;
      timer_q <= '0;
      resp_valid_q <= '0;
      sin_reset_q <= 1'b1;
    end else begin
      resp_valid_q <= '0;
      sin_reset_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          theta_q <= req_theta[32*gidx +: 32];
          prec_q <= req_prec[4*gidx +: 4];
          gidx_q <= gidx;
          sin_reset_q <= 1'b1;
          state_q <= LAUNCH;
        end
        LAUNCH: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          timer_q <= timer_d;
          if (done_ok || timed_out) begin
            res_q <= done_ok ? sin_result : '0;
            err_q <= !done_ok;
            resp_valid_q <= NREQ'(1) << gidx_q;
            state_q <= RESPOND;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sin_arbiter.sv
// tb_sin_arbiter: scoreboard bench for sin_arbiter with a behavioural sin unit.
module tb_sin_arbiter;
  localparam int NREQ = 4;
  localparam int TO = 16;
  logic clk = 0, reset = 0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*32-1:0] req_theta = '0;
  logic [NREQ*4-1:0] req_prec = '0;
  logic [NREQ-1:0] req_ready, resp_valid;
  logic [31:0] resp_data, sin_theta;
  logic [31:0] sin_result = '0;
  logic [3:0] sin_prec;
  logic resp_err, busy, sin_reset;
  logic sin_done = 0;

  sin_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_theta(req_theta),
    .req_prec(req_prec), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy), .sin_reset(sin_reset),
    .sin_theta(sin_theta), .sin_prec(sin_prec), .sin_result(sin_result), .sin_done(sin_done)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic [31:0] data; logic err; } exp_t;
  typedef struct { int mode; int dly; } op_t;
  exp_t rq[$];
  int gq[$];
  op_t mq[$];
  int rdy_cyc[$], rsp_cyc[$];
  int n_chk = 0, n_fail = 0, cyc = 0, sr_pulses = 0;
  logic sr_prev = 1;
  logic [NREQ-1:0] rdy_snap = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sinf(input logic [31:0] th, input logic [3:0] p);
    if (th == 32'h0 && p == 4'ha) return 32'h0;
    if (th == 32'h3f800000 && p == 4'h9) return 32'h3f576aa5;
    if (th == 32'h3f99999a && p == 4'h7) return 32'h3f6e9a1c;
    return 32'hbad0bad0;
  endfunction

  // sin unit model; mode 0 = done after dly cycles, 1 = stale done then late done, 2 = never
  initial begin
    int cnt;
    op_t op;
    cnt = 0;
    op.mode = 0;
    op.dly = 2;
    forever begin
      @(negedge clk);
      if (sin_reset && busy) begin
        if (mq.size() > 0) op = mq.pop_front();
        else begin op.mode = 0; op.dly = 2; end
        cnt = 0;
      end else cnt++;
      if (op.mode == 0) begin
        sin_done = !sin_reset && cnt > op.dly;
        sin_result = sin_done ? sinf(sin_theta, sin_prec) : 32'h0;
      end else if (op.mode == 1) begin
        sin_done = cnt <= 1 || cnt >= 6;
        sin_result = cnt <= 1 ? 32'hdeadbeef : sinf(sin_theta, sin_prec);
      end else begin
        sin_done = 0;
        sin_result = 32'h0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (sin_reset && !sr_prev) sr_pulses++;
    sr_prev = sin_reset;
    rdy_snap = req_ready;
    if (|req_ready) begin
      rdy_cyc.push_back(cyc);
      if (gq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL grant: unexpected req_ready %b", req_ready);
      end else chk("grant", 32'(req_ready), 32'(1) << gq.pop_front());
    end
    if (|resp_valid) begin
      rsp_cyc.push_back(cyc);
      if (rq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL resp: unexpected resp_valid %b", resp_valid);
      end else begin
        e = rq.pop_front();
        chk("resp_valid", 32'(resp_valid), 32'(1) << e.idx);
        chk("resp_data", resp_data, e.data);
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  // Requesters drop valid right after the edge that accepted them.
  initial forever begin
    @(posedge clk);
    #1;
    req_valid = req_valid & ~rdy_snap;
  end

  task automatic issue(input int i, input logic [31:0] th, input logic [3:0] p);
    req_theta[i*32 +: 32] = th;
    req_prec[i*4 +: 4] = p;
    req_valid[i] = 1'b1;
  endtask

  task automatic expect_op(input int i, input logic [31:0] d, input logic er, input int mode, input int dly);
    exp_t e;
    op_t o;
    e.idx = i; e.data = d; e.err = er;
    o.mode = mode; o.dly = dly;
    gq.push_back(i);
    rq.push_back(e);
    mq.push_back(o);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((rq.size() > 0 || gq.size() > 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk({name, " drained"}, 32'(rq.size() + gq.size()), 32'd0);
    rq.delete(); gq.delete(); mq.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b0001;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset sin_reset", 32'(sin_reset), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset resp_data", resp_data, 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    chk("reset sin_theta", sin_theta, 32'd0);
    chk("reset sin_prec", 32'(sin_prec), 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    sr_pulses = 0;
    expect_op(1, 32'h3f576aa5, 0, 0, 10);
    issue(1, 32'h3f800000, 4'h9);
    drain("single");
    chk("sin_reset pulses", 32'(sr_pulses), 32'd1);

    apply_reset();
    expect_op(0, 32'h00000000, 0, 0, 3);
    expect_op(1, 32'h3f576aa5, 0, 0, 3);
    expect_op(2, 32'h3f6e9a1c, 0, 0, 3);
    expect_op(3, 32'h00000000, 0, 0, 3);
    issue(0, 32'h00000000, 4'ha);
    issue(1, 32'h3f800000, 4'h9);
    issue(2, 32'h3f99999a, 4'h7);
    issue(3, 32'h00000000, 4'ha);
    drain("all four");

    rdy_cyc.delete(); rsp_cyc.delete();
    expect_op(0, 32'h3f576aa5, 0, 0, 1);
    expect_op(1, 32'h3f6e9a1c, 0, 0, 1);
    issue(0, 32'h3f800000, 4'h9);
    issue(1, 32'h3f99999a, 4'h7);
    drain("latency");
    chk("latency events", 32'(rdy_cyc.size() * 10 + rsp_cyc.size()), 32'd22);
    if (rdy_cyc.size() == 2 && rsp_cyc.size() == 2) begin
      chk("accept to resp", 32'(rsp_cyc[0] - rdy_cyc[0]), 32'd4);
      chk("resp to next accept", 32'(rdy_cyc[1] - rsp_cyc[0]), 32'd1);
      chk("accept to resp 2", 32'(rsp_cyc[1] - rdy_cyc[1]), 32'd4);
    end

    expect_op(2, 32'h3f6e9a1c, 0, 1, 0);
    issue(2, 32'h3f99999a, 4'h7);
    drain("stale done");

    rdy_cyc.delete(); rsp_cyc.delete();
    expect_op(3, 32'h0, 1, 2, 0);
    expect_op(0, 32'h3f576aa5, 0, 0, 4);
    issue(3, 32'h3f800000, 4'h9);
    issue(0, 32'h3f800000, 4'h9);
    drain("timeout");
    if (rdy_cyc.size() == 2 && rsp_cyc.size() == 2)
      chk("timeout latency", 32'(rsp_cyc[0] - rdy_cyc[0]), 32'd18);
    else chk("timeout events", 32'(rdy_cyc.size() * 10 + rsp_cyc.size()), 32'd22);

    gq.push_back(1);
    begin
      op_t o;
      o.mode = 2; o.dly = 0;
      mq.push_back(o);
    end
    issue(1, 32'h3f800000, 4'h9);
    repeat (6) @(posedge clk);
    #1;
    chk("busy before reset", 32'(busy), 32'd1);
    reset = 0;
    #1;
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset sin_reset", 32'(sin_reset), 32'd1);
    chk("mid reset resp_valid", 32'(resp_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    mq.delete();
    chk("grant before reset", 32'(gq.size()), 32'd0);
    reset = 1;
    @(posedge clk);
    #1;
    expect_op(1, 32'h3f576aa5, 0, 0, 3);
    expect_op(2, 32'h00000000, 0, 0, 3);
    issue(1, 32'h3f800000, 4'h9);
    issue(2, 32'h00000000, 4'ha);
    drain("after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
